alm_soa_pipe: RTL and testbench

Parametrised, pipelined approximate logarithmic multiplier (Mitchell-style log/antilog with set-one-adder truncation) for the approximate-arithmetic datapath. It generalises the fixed 16-bit combinational ALM-SOA multiplier in three ways: configurable operand width and kept fraction bits, per-transaction signed/unsigned mode, and an exact/one's-complement absolute-value option. It is a 3-stage pipeline with valid/ready handshakes and a tag that passes through unchanged.

---
 rtl/alm_soa_pipe.sv | 117 +++++++++++
 tb/tb_alm_soa_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alm_soa_pipe.sv
// Pipelined approximate logarithmic multiplier: Mitchell log/antilog with set-one-adder truncation.
// Three stages share one advance signal, so a stalled output freezes the whole pipe.
module alm_soa_pipe #(
   parameter int WIDTH     = 16,
   parameter int FRAC_BITS = 5,
   parameter int ABS_EXACT = 0,
   parameter int TAG_W     = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   x_i,
   input  logic [WIDTH-1:0]   y_i,
   input  logic               signed_i,
   input  logic [TAG_W-1:0]   tag_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [2*WIDTH-1:0] p_o,
   output logic [TAG_W-1:0]   tag_o
);
   localparam int N  = WIDTH;
   localparam int M  = FRAC_BITS;
   localparam int K  = $clog2(WIDTH);
   localparam int LW = K + M + 1;
   localparam int EW = K + M + 2;

   // Encoded operand: {sign, k, frac, g}
   typedef logic [EW-1:0] enc_t;

   function automatic enc_t log_enc(input logic [N-1:0] x, input logic sg);
      logic         s;
      logic [N-1:0] a;
      logic [N-1:0] nrm;
      logic [K-1:0] k;
      logic [M:0]   f;
      s = sg & x[N-1];
      if (ABS_EXACT != 0) a = s ? -x : x;
      else                a = x ^ {N{s}};
      k = '0;
      for (int unsigned i = 0; i < N; i++)
         if (a[i]) k = K'(i);
      nrm = a << (N - 1 - int'(k));
      f   = nrm[N-2 -: M+1];
      return {s, k, f[M:1], f[0]};
   endfunction

   logic             adv;
   logic             v1, v2, v3;
   enc_t             ex, ey;
   logic [K+M-1:0]   lx1, ly1;
   logic             gx1, gy1, sp1, z1;
   logic [TAG_W-1:0] t1;
   logic [LW-1:0]    l2;
   logic             sp2, z2;
   logic [TAG_W-1:0] t2;
   logic [K:0]       kr;
   logic [M-1:0]     fr;
   logic [N-1:0]     mant;
   logic [2*N-1:0]   mag, pv;

   assign adv         = ~v3 | out_ready_i;
   assign in_ready_o  = adv;
   assign out_valid_o = v3;
   assign ex          = log_enc(x_i, signed_i);
   assign ey          = log_enc(y_i, signed_i);

   always_ff @(posedge clk_i) begin
      if (adv) begin
         if (in_valid_i) begin
            lx1 <= ex[EW-2:1];
            ly1 <= ey[EW-2:1];
            gx1 <= ex[0];
            gy1 <= ey[0];
            sp1 <= ex[EW-1] ^ ey[EW-1];
            z1  <= (x_i == '0) | (y_i == '0);
            t1  <= tag_i;
         end
         if (v1) begin
            l2  <= LW'(lx1) + LW'(ly1) + LW'(gx1 & gy1);
            sp2 <= sp1;
            z2  <= z1;
            t2  <= t1;
         end
      end
   end

   // Mantissa 1.fr111.. with N-1 fraction bits, scaled by 2^kr and truncated to an integer
   always_comb begin
      kr   = l2[K+M:M];
      fr   = l2[M-1:0];
      mant = {1'b1, fr, {(N-1-M){1'b1}}};
      mag  = (2*N)'(((3*N-1)'(mant) << kr) >> (N - 1));
      if (ABS_EXACT != 0) pv = sp2 ? -mag : mag;
      else                pv = mag ^ {(2*N){sp2}};
      if (z2) pv = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         v3    <= 1'b0;
         p_o   <= '0;
         tag_o <= '0;
      end else if (adv) begin
         v1 <= in_valid_i;
         v2 <= v1;
         v3 <= v2;
         if (v2) begin
            p_o   <= pv;
            tag_o <= t2;
         end
      end
   end

endmodule

// File: tb/tb_alm_soa_pipe.sv
// Scoreboard bench for alm_soa_pipe: directed cases, backpressure, reset flush and a
// random sweep over several WIDTH/FRAC_BITS/ABS_EXACT configurations.
module tb_alm_soa_pipe;
   localparam int NC = 6;
   localparam int TW = 4;

   function automatic int cfg_w(input int c);
      case (c)
         0, 1:    return 16;
         2, 3:    return 8;
         default: return 32;
      endcase
   endfunction

   function automatic int cfg_m(input int c);
      case (c)
         0, 1:    return 5;
         2:       return 1;
         3:       return 6;
         4:       return 1;
         default: return 30;
      endcase
   endfunction

   function automatic int cfg_a(input int c);
      case (c)
         1, 3, 4: return 1;
         default: return 0;
      endcase
   endfunction

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid [NC];
   logic          in_ready [NC];
   logic          sgn [NC];
   logic          out_valid [NC];
   logic          out_ready [NC];
   logic [31:0]   x [NC];
   logic [31:0]   y [NC];
   logic [TW-1:0] tag_in [NC];
   logic [TW-1:0] tag_out [NC];
   logic [63:0]   p [NC];

   always #5 clk = ~clk;

   for (genvar c = 0; c < NC; c++) begin : g_dut
      localparam int W = cfg_w(c);
      logic [2*W-1:0] pw;
      alm_soa_pipe #(
         .WIDTH(W), .FRAC_BITS(cfg_m(c)), .ABS_EXACT(cfg_a(c)), .TAG_W(TW)
      ) dut (
         .clk_i(clk), .rst_i(rst),
         .in_valid_i(in_valid[c]), .in_ready_o(in_ready[c]),
         .x_i(x[c][W-1:0]), .y_i(y[c][W-1:0]), .signed_i(sgn[c]), .tag_i(tag_in[c]),
         .out_valid_o(out_valid[c]), .out_ready_i(out_ready[c]),
         .p_o(pw), .tag_o(tag_out[c])
      );
      assign p[c] = 64'(pw);
   end

   typedef struct {
      logic [63:0]   p;
      logic [TW-1:0] tag;
      int            t;
   } exp_t;

   exp_t        sbq [NC][$];
   logic [63:0] nxt [NC];
   logic [63:0] held [NC];
   logic [TW-1:0] held_tag [NC];
   bit          held_v [NC];
   bit          acc [NC];
   int          blk [NC];
   int          cyc, ncmp, nerr;
   bit          lat_on;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic void enc(input logic [31:0] xi, input bit sg, input int n, input int m,
                               input int ab, output bit s, output int k, output int fr,
                               output bit g);
      logic [63:0] a, nrm, msk;
      msk = (64'd1 << n) - 64'd1;
      s   = sg && xi[n-1];
      a   = {32'd0, xi} & msk;
      if (s) a = (ab != 0) ? ((~a + 64'd1) & msk) : (a ^ msk);
      k = 0;
      for (int i = 0; i < n; i++)
         if (a[i]) k = i;
      nrm = (a << (n - 1 - k)) & msk;
      fr  = int'((nrm >> (n - 1 - m)) & ((64'd1 << m) - 64'd1));
      g   = nrm[n-2-m];
   endfunction

   function automatic logic [63:0] model(input int c, input logic [31:0] xi, input logic [31:0] yi,
                                         input bit sg);
      int n, m, ab, kk, kx, ky, fx, fy, kr;
      bit sx, sy, gx, gy;
      longint l, fr;
      logic [127:0] mant, w;
      logic [63:0] mag, msk2;
      logic [31:0] msk;
      n = cfg_w(c);
      m = cfg_m(c);
      ab = cfg_a(c);
      msk = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      if ((xi & msk) == 32'd0 || (yi & msk) == 32'd0) return 64'd0;
      enc(xi, sg, n, m, ab, sx, kx, fx, gx);
      enc(yi, sg, n, m, ab, sy, ky, fy, gy);
      kk = $clog2(n);
      l  = ((longint'(kx) << m) + fx) + ((longint'(ky) << m) + fy) + longint'(gx & gy);
      l  = l & ((longint'(1) << (kk + m + 1)) - 1);
      kr = int'(l >> m);
      fr = l & ((longint'(1) << m) - 1);
      mant = (128'd1 << (n - 1)) | (128'(fr) << (n - 1 - m)) | ((128'd1 << (n - 1 - m)) - 128'd1);
      w    = (mant << kr) >> (n - 1);
      msk2 = (n == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * n)) - 64'd1);
      mag  = w[63:0] & msk2;
      if (sx ^ sy) mag = (ab != 0) ? ((~mag + 64'd1) & msk2) : (mag ^ msk2);
      return mag;
   endfunction

   function automatic logic [31:0] pick(input int n);
      logic [31:0] v, msk;
      msk = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      case ($urandom_range(7))
         0:       v = 32'd0;
         1:       v = 32'hFFFF_FFFF;
         2:       v = 32'd1 << (n - 1);
         3:       v = 32'd1;
         default: v = $urandom;
      endcase
      return v & msk;
   endfunction

   task automatic idle_all();
      for (int c = 0; c < NC; c++) begin
         in_valid[c]  = 1'b0;
         x[c]         = '0;
         y[c]         = '0;
         sgn[c]       = 1'b0;
         tag_in[c]    = '0;
         nxt[c]       = '0;
         out_ready[c] = 1'b1;
      end
   endtask

   task automatic drive(input int c, input logic [31:0] xv, input logic [31:0] yv, input bit s,
                        input logic [TW-1:0] t, input logic [63:0] e);
      in_valid[c] = 1'b1;
      x[c]        = xv;
      y[c]        = yv;
      sgn[c]      = s;
      tag_in[c]   = t;
      nxt[c]      = e;
   endtask

   // One clock: sample at the falling edge, then step past the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
         acc[c] = 1'b0;
         if (rst) begin
            held_v[c] = 1'b0;
         end else begin
            if (in_valid[c] && !in_ready[c]) blk[c]++;
            if (out_valid[c] && !out_ready[c]) begin
               if (held_v[c]) begin
                  check($sformatf("c%0d stall_p", c), p[c], held[c]);
                  check($sformatf("c%0d stall_tag", c), 64'(tag_out[c]), 64'(held_tag[c]));
               end
               held[c]     = p[c];
               held_tag[c] = tag_out[c];
               held_v[c]   = 1'b1;
            end else begin
               held_v[c] = 1'b0;
            end
            if (out_valid[c] && out_ready[c]) begin
               if (sbq[c].size() == 0) begin
                  check($sformatf("c%0d spurious_out", c), 64'(out_valid[c]), 64'd0);
               end else begin
                  e = sbq[c].pop_front();
                  check($sformatf("c%0d p tag%0d", c, e.tag), p[c], e.p);
                  check($sformatf("c%0d tag", c), 64'(tag_out[c]), 64'(e.tag));
                  if (lat_on) check($sformatf("c%0d latency", c), 64'(cyc - e.t), 64'd3);
               end
            end
            if (in_valid[c] && in_ready[c]) begin
               acc[c] = 1'b1;
               e.p    = nxt[c];
               e.tag  = tag_in[c];
               e.t    = cyc;
               sbq[c].push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   typedef struct {
      int          c;
      logic [31:0] x;
      logic [31:0] y;
      bit          s;
      logic [63:0] e;
   } dir_t;

   dir_t dirs [11] = '{
      '{0, 32'd3,      32'd3,      1'b0, 64'h0000_0008},
      '{0, 32'h7FFF,   32'h7FFF,   1'b0, 64'h3FFF_C000},
      '{0, 32'hFFFF,   32'hFFFF,   1'b0, 64'hFFFF_0000},
      '{0, 32'hFFFD,   32'd3,      1'b1, 64'hFFFF_FFF9},
      '{1, 32'hFFFD,   32'd3,      1'b1, 64'hFFFF_FFF8},
      '{0, 32'hFFFD,   32'd3,      1'b0, 64'h0002_FFFC},
      '{0, 32'd0,      32'd1234,   1'b0, 64'h0000_0000},
      '{0, 32'd1234,   32'd0,      1'b1, 64'h0000_0000},
      '{0, 32'hFFFF,   32'd5,      1'b1, 64'hFFFF_FFFA},
      '{1, 32'hFFFF,   32'd5,      1'b1, 64'hFFFF_FFFB},
      '{1, 32'd3,      32'd3,      1'b0, 64'h0000_0008}
   };

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, nstall;
      int tcnt [NC];
      logic [31:0] xv, yv;
      bit sv;

      ncmp = 0;
      nerr = 0;
      cyc  = 0;
      lat_on = 1'b0;
      for (int c = 0; c < NC; c++) begin
         blk[c] = 0;
         tcnt[c] = 0;
         held_v[c] = 1'b0;
      end
      idle_all();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < NC; c++) begin
         check($sformatf("c%0d rst out_valid", c), 64'(out_valid[c]), 64'd0);
         check($sformatf("c%0d rst p", c), p[c], 64'd0);
         check($sformatf("c%0d rst tag", c), 64'(tag_out[c]), 64'd0);
         check($sformatf("c%0d rst in_ready", c), 64'(in_ready[c]), 64'd1);
      end

      // Directed cases at full rate, always-ready consumer
      lat_on = 1'b1;
      for (int i = 0; i < 11; i++) begin
         idle_all();
         drive(dirs[i].c, dirs[i].x, dirs[i].y, dirs[i].s, TW'(i), dirs[i].e);
         tick();
      end
      idle_all();
      for (int i = 0; i < 5; i++) tick();
      for (int c = 0; c < 2; c++)
         check($sformatf("c%0d directed drained", c), 64'(sbq[c].size()), 64'd0);

      // Backpressure: six tagged pairs, consumer stalls four cycles at first output
      lat_on = 1'b0;
      sent = 0;
      nstall = 0;
      blk[0] = 0;
      for (int i = 0; i < 40 && (sent < 6 || sbq[0].size() > 0); i++) begin
         idle_all();
         if (sent < 6) begin
            xv = 32'(1000 + 777 * sent);
            yv = 32'(300 + 91 * sent);
            drive(0, xv, yv, 1'b0, TW'(sent), model(0, xv, yv, 1'b0));
         end
         if (out_valid[0] && nstall < 4) begin
            out_ready[0] = 1'b0;
            nstall++;
         end
         tick();
         if (acc[0]) sent++;
      end
      check("bp sent", 64'(sent), 64'd6);
      check("bp blocked cycles", 64'(blk[0]), 64'd4);
      check("bp drained", 64'(sbq[0].size()), 64'd0);

      // Reset with three items in flight
      idle_all();
      for (int i = 0; i < 3; i++) begin
         idle_all();
         drive(0, 32'(50 + i), 32'd7, 1'b0, TW'(8 + i), 64'd0);
         tick();
      end
      idle_all();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < NC; c++) sbq[c].delete();
      check("flush out_valid", 64'(out_valid[0]), 64'd0);
      check("flush p", p[0], 64'd0);
      check("flush tag", 64'(tag_out[0]), 64'd0);
      lat_on = 1'b1;
      drive(0, 32'd3, 32'd3, 1'b0, TW'(12), 64'd8);
      tick();
      idle_all();
      for (int i = 0; i < 6; i++) tick();
      check("post-flush drained", 64'(sbq[0].size()), 64'd0);

      // Random sweep, all configurations, random consumer readiness
      lat_on = 1'b0;
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < NC; c++) begin
            in_valid[c] = ($urandom_range(3) != 0);
            xv = pick(cfg_w(c));
            yv = pick(cfg_w(c));
            sv = 1'($urandom_range(1));
            x[c] = xv;
            y[c] = yv;
            sgn[c] = sv;
            tag_in[c] = TW'(tcnt[c]);
            nxt[c] = model(c, xv, yv, sv);
            out_ready[c] = ($urandom_range(3) != 0);
         end
         tick();
         for (int c = 0; c < NC; c++)
            if (acc[c]) tcnt[c]++;
      end
      idle_all();
      for (int i = 0; i < 10; i++) tick();
      for (int c = 0; c < NC; c++)
         check($sformatf("c%0d sweep drained", c), 64'(sbq[c].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
